spi_master_engine: RTL and testbench
====================================

Name: spi_master_engine

Overview:
- Memory-mapped SPI master for the PIO area.
- Replaces the ad-hoc shifter, clock mux and DMAGO flag in the glue logic with one self-contained engine.
- Provides a runtime-selectable SCLK prescaler, all four CPOL/CPHA modes, MSB- or LSB-first shifting, software-managed chip selects, a busy/done/collision status, and a level interrupt output.
- Sits behind a PIO page decode and drives the 8-bit host data bus through the glue read mux.

Parameters:
- NUM_CS, 4, number of chip-select outputs (1..8).
- DIV_W, 3, width of the prescaler select field. Half-period = 2^sel clocks, sel in 0..2^DIV_W-1.

Ports:
- clock  in  1  system clock (x8m)
- reset_n  in  1  asynchronous active-low reset (sysrst_n)
- chip_enable  in  1  register window select. Level, held for the whole bus cycle.
- read_write_n  in  1  1 = read, 0 = write
- host_address  in  2  register select (xadl[7:6])
- host_din  in  8  write data
- host_qout  out  8  read data (combinational from registers)
- irq  out  1  level interrupt = done & ie
- spi_sclk  out  1  serial clock
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in
- spi_cs_n  out  NUM_CS  chip selects, active low

Behaviour:
- Registers:
  - addr 0 DATA. Write starts a transfer. Read returns the last received byte and clears done.
  - addr 1 CTRL = {ie, lsb_first, cpha, cpol, rsvd, sel[DIV_W-1:0]}, with sel occupying bits [DIV_W-1:0].
  - addr 2 STATUS = {5'b0, collision, done, busy}. A write of any value clears collision.
  - addr 3 CS. spi_cs_n = ~cs_reg[NUM_CS-1:0]. Unused upper bits read as 0.
- Write strobes:
  - Each write strobe is the rising edge of (chip_enable & ~read_write_n), registered in clock.
  - A write therefore acts exactly once per bus cycle, one clock after the strobe is first sampled.
  - The DATA read-clear of done uses the falling edge of (chip_enable & read_write_n & addr==0).
- Reset values:
  - all registers 0, cs_reg 0, so spi_cs_n all 1
  - spi_sclk = 0, spi_mosi = 0, irq = 0
  - FSM in IDLE, host_qout = 0
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on a DATA write strobe.
    - Load the shift register from host_din.
    - Latch cpol/cpha/lsb_first/sel into working copies; CTRL writes during the transfer do not affect it.
    - Clear the prescaler and the edge counter.
    - busy = 1 on the next clock.
  - SHIFT:
    - The prescaler pulses tick every 2^sel clocks. Each tick toggles spi_sclk (idle level = cpol).
    - A 4-bit edge counter runs 1..16.
    - cpha = 0: first bit is on spi_mosi from entry to SHIFT. Sample miso on odd edges, shift out on even edges.
    - cpha = 1: shift out on odd edges, sample on even edges.
    - Shift direction follows lsb_first.
  - SHIFT -> DONE on the 16th edge. spi_sclk is then back at cpol; the received byte is latched into rx_reg.
  - DONE (one clock): busy = 0, done = 1 -> IDLE.
  - A transfer occupies exactly 16*2^sel clocks in SHIFT.
- Collision:
  - A DATA write while busy is ignored: no reload, no restart.
  - It sets collision (sticky).
- Done handling:
  - done stays set until a DATA read or the next transfer start.
  - If the start and the read-clear fall on the same clock, start wins and done = 0.
- spi_mosi holds its last bit after a transfer until the next load.
- CS writes take effect on the next clock even while busy. Software must deassert CS only after busy = 0.
- Asynchronous reset mid-transfer:
  - immediate return to IDLE, all outputs at reset values
  - no done, no irq

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- Defined:
  - CTRL bit 3 (rsvd) becomes loop.
  - When loop = 1, the sampled data is spi_mosi instead of spi_miso, and spi_sclk/spi_mosi still toggle externally.
  - Bit 3 is readable.
- Undefined: bit 3 reads 0 and writes to it are ignored.

Decomposition:
- Package spi_master_pkg:
  - register address constants SPI_ADDR_DATA/CTRL/STATUS/CS
  - CTRL bit-index constants
  - FSM state encoding (2-bit)
  - SPI_EDGES = 16
- Sub-module spi_clock_prescaler:
  - inputs clock, reset_n, clear, sel
  - output tick, with a free counter of 2^DIV_W-1 bits compared against the sel mask

Test Plan:
- Mode 0, sel = 0, CS = 0x01, write DATA 0xA5, miso model returns 0x3C:
  - spi_cs_n = 4'b1110
  - spi_mosi bits on sampling edges are 1,0,1,0,0,1,0,1
  - busy high for 16 clocks, then done
  - DATA read = 0x3C, done cleared
- Mode 3, sel = 2, lsb_first, write 0x81:
  - sclk idles high, half-period 4 clocks, transfer 64 clocks
  - mosi order is 1,0,0,0,0,0,0,1 LSB first
  - received byte bit-reversed relative to MSB-first capture
- Write DATA 0x55 mid-transfer of 0xA5:
  - collision = 1, transfer continues with 0xA5 unchanged
  - STATUS write clears collision
- ie = 1, complete a transfer:
  - irq rises the clock after the last edge
  - stays high until DATA read, then 0
- Assert reset_n low on the 7th edge:
  - spi_sclk = cpol reset (0), spi_cs_n all 1, busy/done/irq = 0
  - a new transfer after release completes normally
- With SPI_MASTER_LOOPBACK_EN, loop = 1, write 0xC3, miso held 0:
  - DATA read = 0xC3
  - without the macro, same stimulus -> 0x00 and CTRL bit 3 reads 0

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared constants for the PIO SPI master: register map, CTRL bit positions,
// FSM encoding and the transmit bit-select helper.
package spi_master_pkg;

    localparam logic [1:0] SPI_ADDR_DATA   = 2'd0;
    localparam logic [1:0] SPI_ADDR_CTRL   = 2'd1;
    localparam logic [1:0] SPI_ADDR_STATUS = 2'd2;
    localparam logic [1:0] SPI_ADDR_CS     = 2'd3;

    localparam int CTRL_IE   = 7;
    localparam int CTRL_LSB  = 6;
    localparam int CTRL_CPHA = 5;
    localparam int CTRL_CPOL = 4;
    localparam int CTRL_LOOP = 3;

    localparam int SPI_EDGES = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

    // idx counts bits in transmission order, so 0 is the first bit on the wire.
    function automatic logic tx_bit(input logic [7:0] d, input logic [2:0] idx, input logic lsb);
        return lsb ? d[idx] : d[3'd7 - idx];
    endfunction

endpackage

// File: rtl/spi_master_engine_if.sv
// Host-side PIO register bus of the SPI master engine.
interface spi_master_engine_if;
    // Bus cycle: chip_enable is held high with read_write_n, host_address and
    // host_din stable for the whole cycle (at least two clocks). A write acts
    // once per cycle; host_qout is valid combinationally while a read is held.
    logic       chip_enable;
    logic       read_write_n;
    logic [1:0] host_address;
    logic [7:0] host_din;
    logic [7:0] host_qout;
    logic       irq;

    modport master (
        output chip_enable, read_write_n, host_address, host_din,
        input  host_qout, irq
    );

    modport slave (
        input  chip_enable, read_write_n, host_address, host_din,
        output host_qout, irq
    );
endinterface

// File: rtl/spi_clock_prescaler.sv
// SCLK prescaler: tick every 2^sel clocks from a free counter, held at zero by clear.
module spi_clock_prescaler #(
    parameter int DIV_W = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] sel,
    output logic             tick
);
    localparam int CW = (1 << DIV_W) - 1;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_mask;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < CW; i++) w_mask[i] = (i < int'(sel));
    end

    // sel = 0 gives an empty mask, i.e. a tick on every clock.
    assign tick = ~clear & ((r_cnt & w_mask) == w_mask);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   r_cnt <= '0;
        else if (clear) r_cnt <= '0;
        else            r_cnt <= r_cnt + CW'(1);
    end
endmodule

// File: rtl/spi_master_engine.sv
// Memory-mapped SPI master: DATA/CTRL/STATUS/CS registers, four SPI modes, prescaled SCLK.
// Optional SPI_MASTER_LOOPBACK_EN turns CTRL bit 3 into an internal mosi->miso loop.
module spi_master_engine
    import spi_master_pkg::*;
#(
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    spi_master_engine_if.slave  host,
    output logic                spi_sclk,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic [NUM_CS-1:0]   spi_cs_n,
    output spi_state_e          o_dbg_state
);
    localparam logic [7:0] SEL_MASK = 8'((1 << DIV_W) - 1);
`ifdef SPI_MASTER_LOOPBACK_EN
    localparam logic [7:0] CTRL_WMASK = 8'hF8 | SEL_MASK;
`else
    localparam logic [7:0] CTRL_WMASK = 8'hF0 | SEL_MASK;
`endif

    spi_state_e        r_state, w_next_state;
    logic              r_wr_prev, r_wr_stb, r_rd_prev;
    logic [7:0]        r_ctrl;
    logic [NUM_CS-1:0] r_cs;
    logic              r_collision, r_done;
    logic [7:0]        r_tx, r_rx_sh, r_rx;
    logic              r_sclk, r_mosi;
    logic [3:0]        r_edge_cnt;
    logic              r_cpha, r_lsb;
    logic [DIV_W-1:0]  r_sel;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic              r_loop;
`endif

    logic       w_wr_level, w_rd_level, w_rd_fall;
    logic       w_wr_data, w_start, w_collide;
    logic       w_busy, w_psc_clear, w_tick, w_last;
    logic       w_sample_edge, w_out_edge, w_sample_in;
    logic [2:0] w_out_idx;
    logic [7:0] w_rx_next, w_qout;

    assign w_wr_level = host.chip_enable & ~host.read_write_n;
    assign w_rd_level = host.chip_enable & host.read_write_n & (host.host_address == SPI_ADDR_DATA);
    assign w_rd_fall  = r_rd_prev & ~w_rd_level;
    assign w_wr_data  = r_wr_stb & (host.host_address == SPI_ADDR_DATA);
    // Only IDLE accepts a start; a DATA write in SHIFT or DONE is a collision.
    assign w_start    = w_wr_data & (r_state == ST_IDLE);
    assign w_collide  = w_wr_data & (r_state != ST_IDLE);

    spi_clock_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (w_psc_clear),
        .sel     (r_sel),
        .tick    (w_tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_start) w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_last)  w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state == ST_SHIFT);
        w_psc_clear = (r_state != ST_SHIFT);
    end

    // Edge n (1..16) is r_edge_cnt = n-1, so odd edges have r_edge_cnt[0] = 0.
    assign w_last        = w_tick & (r_edge_cnt == 4'(SPI_EDGES - 1));
    assign w_sample_edge = w_tick & (r_cpha ? r_edge_cnt[0] : ~r_edge_cnt[0]);
    assign w_out_edge    = w_tick & (r_cpha ? ~r_edge_cnt[0] : (r_edge_cnt[0] & ~w_last));
    assign w_out_idx     = r_cpha ? r_edge_cnt[3:1] : (r_edge_cnt[3:1] + 3'd1);
`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_sample_in   = r_loop ? r_mosi : spi_miso;
`else
    assign w_sample_in   = spi_miso;
`endif
    assign w_rx_next     = r_lsb ? {w_sample_in, r_rx_sh[7:1]} : {r_rx_sh[6:0], w_sample_in};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx       <= '0;
            r_rx_sh    <= '0;
            r_rx       <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_edge_cnt <= '0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_sel      <= '0;
`ifdef SPI_MASTER_LOOPBACK_EN
            r_loop     <= 1'b0;
`endif
        end else if (w_start) begin
            r_tx       <= host.host_din;
            r_rx_sh    <= '0;
            r_sclk     <= r_ctrl[CTRL_CPOL];
            r_mosi     <= tx_bit(host.host_din, 3'd0, r_ctrl[CTRL_LSB]);
            r_edge_cnt <= '0;
            r_cpha     <= r_ctrl[CTRL_CPHA];
            r_lsb      <= r_ctrl[CTRL_LSB];
            r_sel      <= r_ctrl[DIV_W-1:0];
`ifdef SPI_MASTER_LOOPBACK_EN
            r_loop     <= r_ctrl[CTRL_LOOP];
`endif
        end else if (w_tick) begin
            r_sclk     <= ~r_sclk;
            r_edge_cnt <= r_edge_cnt + 4'd1;
            if (w_sample_edge) r_rx_sh <= w_rx_next;
            if (w_out_edge)    r_mosi  <= tx_bit(r_tx, w_out_idx, r_lsb);
            // With cpha = 1 the final sample lands on the 16th edge itself.
            if (w_last)        r_rx    <= r_cpha ? w_rx_next : r_rx_sh;
        end else if (r_state == ST_IDLE) begin
            r_sclk <= r_ctrl[CTRL_CPOL];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_prev   <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_rd_prev   <= 1'b0;
            r_ctrl      <= '0;
            r_cs        <= '0;
            r_collision <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_wr_prev <= w_wr_level;
            r_wr_stb  <= w_wr_level & ~r_wr_prev;
            r_rd_prev <= w_rd_level;
            if (r_wr_stb && host.host_address == SPI_ADDR_CTRL) r_ctrl <= host.host_din & CTRL_WMASK;
            if (r_wr_stb && host.host_address == SPI_ADDR_CS)   r_cs   <= host.host_din[NUM_CS-1:0];
            if (r_wr_stb && host.host_address == SPI_ADDR_STATUS) r_collision <= 1'b0;
            else if (w_collide)                                   r_collision <= 1'b1;
            if (w_start)                          r_done <= 1'b0;
            else if (r_state == ST_SHIFT && w_last) r_done <= 1'b1;
            else if (w_rd_fall)                   r_done <= 1'b0;
        end
    end

    always_comb begin
        w_qout = '0;
        if (host.chip_enable && host.read_write_n) begin
            unique case (host.host_address)
                SPI_ADDR_DATA:   w_qout = r_rx;
                SPI_ADDR_CTRL:   w_qout = r_ctrl;
                SPI_ADDR_STATUS: w_qout = {5'b0, r_collision, r_done, w_busy};
                SPI_ADDR_CS:     w_qout = 8'(r_cs);
                default:         w_qout = '0;
            endcase
        end
    end

    assign host.host_qout = w_qout;
    assign host.irq       = r_done & r_ctrl[CTRL_IE];
    assign spi_sclk       = r_sclk;
    assign spi_mosi       = r_mosi;
    assign spi_cs_n       = ~r_cs;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine: register access, four-mode shifting, collision,
// irq, mid-transfer reset and the SPI_MASTER_LOOPBACK_EN option.
module tb_spi_master_engine;
  import spi_master_pkg::*;

  localparam int NUM_CS = 4;
  localparam int DIV_W  = 3;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              spi_sclk, spi_mosi, spi_miso;
  logic [NUM_CS-1:0] spi_cs_n;
  spi_state_e        dbg_state;

  int total = 0;
  int bad   = 0;

  spi_master_engine_if host_if();

  spi_master_engine #(.NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .host        (host_if.slave),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_cs_n    (spi_cs_n),
    .o_dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc++;

  int shift_cycles = 0;
  always @(negedge clock) if (dbg_state == ST_SHIFT) shift_cycles++;

  // SPI slave model and wire monitor; the tests only read its counters and queues.
  logic       cur_cpol = 1'b0, cur_cpha = 1'b0;
  logic       s_active = 1'b0, cap_en = 1'b0;
  logic [7:0] s_byte   = 8'h00;
  int         s_base   = 0;
  int         chg_cnt  = 0;
  logic       cap_q[$];
  int         tog_q[$];
  logic [7:0] exp_q[$];

  always @(spi_sclk) begin
    if (s_active && (cur_cpha ? (spi_sclk != cur_cpol) : (spi_sclk == cur_cpol))) chg_cnt++;
    if (cap_en) begin
      tog_q.push_back(cyc);
      if (cur_cpha ? (spi_sclk == cur_cpol) : (spi_sclk != cur_cpol)) cap_q.push_back(spi_mosi);
    end
  end

  always_comb begin
    int k;
    k = chg_cnt - s_base - (cur_cpha ? 1 : 0);
    if (!s_active || k < 0) spi_miso = 1'b0;
    else if (k > 7)         spi_miso = s_byte[0];
    else                    spi_miso = s_byte[7 - k];
  end

  // driver tasks
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clock);
    host_if.chip_enable = 1'b1; host_if.read_write_n = 1'b0;
    host_if.host_address = a;   host_if.host_din = d;
    repeat (3) @(negedge clock);
    host_if.chip_enable = 1'b0; host_if.read_write_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clock);
    host_if.chip_enable = 1'b1; host_if.read_write_n = 1'b1; host_if.host_address = a;
    @(negedge clock);
    d = host_if.host_qout;
    @(negedge clock);
    host_if.chip_enable = 1'b0;
    @(negedge clock);
  endtask

  task automatic arm(input logic cpol, input logic cpha, input logic act, input logic [7:0] sb,
                     output int cb, output int tb, output int scb);
    cur_cpol = cpol; cur_cpha = cpha; s_byte = sb;
    s_base = chg_cnt; s_active = act;
    cb = cap_q.size(); tb = tog_q.size(); scb = shift_cycles;
    cap_en = 1'b1;
  endtask

  task automatic collect(input int cb, input int tb, output logic [7:0] bits, output int nbits,
                         output int ntog, output int hp_min, output int hp_max);
    bits = 8'h00;
    nbits = cap_q.size() - cb;
    ntog  = tog_q.size() - tb;
    for (int i = cb; i < cap_q.size(); i++) bits = {bits[6:0], cap_q[i]};
    hp_min = 1000; hp_max = 0;
    for (int i = tb + 1; i < tog_q.size(); i++) begin
      if (tog_q[i] - tog_q[i-1] < hp_min) hp_min = tog_q[i] - tog_q[i-1];
      if (tog_q[i] - tog_q[i-1] > hp_max) hp_max = tog_q[i] - tog_q[i-1];
    end
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clock);
      if (dbg_state == ST_DONE) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: DONE seen=%0b required=1", name, seen);
    end
    @(negedge clock);
    cap_en = 1'b0; s_active = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    logic [7:0] d;
    total++; if (spi_cs_n !== 4'hF)   begin bad++; $display("FAIL rst_cs_n: got %b exp 1111", spi_cs_n); end
    total++; if (spi_sclk !== 1'b0)   begin bad++; $display("FAIL rst_sclk: got %b exp 0", spi_sclk); end
    total++; if (spi_mosi !== 1'b0)   begin bad++; $display("FAIL rst_mosi: got %b exp 0", spi_mosi); end
    total++; if (host_if.irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b exp 0", host_if.irq); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
    total++; if (host_if.host_qout !== 8'h00) begin bad++; $display("FAIL rst_qout: got %h exp 00", host_if.host_qout); end
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_reg%0d: got %h exp 00", a, d); end
    end
  endtask

  task automatic test_mode0();
    logic [7:0] d, bits; int cb, tb, scb, nb, nt, hmin, hmax;
    bus_write(SPI_ADDR_CS, 8'h01);
    total++; if (spi_cs_n !== 4'b1110) begin bad++; $display("FAIL m0_cs_n: got %b exp 1110", spi_cs_n); end
    bus_write(SPI_ADDR_CTRL, 8'h00);
    arm(1'b0, 1'b0, 1'b1, 8'h3C, cb, tb, scb);
    exp_q.push_back(8'h3C);
    bus_write(SPI_ADDR_DATA, 8'hA5);
    wait_done("m0");
    collect(cb, tb, bits, nb, nt, hmin, hmax);
    total++; if (shift_cycles - scb !== 16) begin bad++; $display("FAIL m0_busy_len: got %0d exp 16", shift_cycles - scb); end
    total++; if (nb !== 8 || bits !== 8'hA5) begin bad++; $display("FAIL m0_mosi: got %h/%0d exp a5/8", bits, nb); end
    total++; if (nt !== 16 || hmin !== 1 || hmax !== 1) begin bad++; $display("FAIL m0_sclk: got tog=%0d hp=%0d..%0d exp 16 1..1", nt, hmin, hmax); end
    total++; if (spi_sclk !== 1'b0) begin bad++; $display("FAIL m0_sclk_end: got %b exp 0", spi_sclk); end
    bus_read(SPI_ADDR_STATUS, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL m0_status_done: got %h exp 02", d); end
    bus_read(SPI_ADDR_DATA, d);
    total++; if (d !== exp_q[0]) begin bad++; $display("FAIL m0_rx: got %h exp %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
    bus_read(SPI_ADDR_STATUS, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL m0_done_clr: got %h exp 00", d); end
  endtask

  task automatic test_mode3();
    logic [7:0] d, bits; int cb, tb, scb, nb, nt, hmin, hmax;
    bus_write(SPI_ADDR_CTRL, 8'h72);
    bus_read(SPI_ADDR_CTRL, d);
    total++; if (d !== 8'h72) begin bad++; $display("FAIL m3_ctrl: got %h exp 72", d); end
    total++; if (spi_sclk !== 1'b1) begin bad++; $display("FAIL m3_sclk_idle: got %b exp 1", spi_sclk); end
    arm(1'b1, 1'b1, 1'b1, 8'hB1, cb, tb, scb);
    exp_q.push_back(8'h8D);
    bus_write(SPI_ADDR_DATA, 8'h81);
    wait_done("m3");
    collect(cb, tb, bits, nb, nt, hmin, hmax);
    total++; if (shift_cycles - scb !== 64) begin bad++; $display("FAIL m3_busy_len: got %0d exp 64", shift_cycles - scb); end
    total++; if (nb !== 8 || bits !== 8'h81) begin bad++; $display("FAIL m3_mosi: got %h/%0d exp 81/8", bits, nb); end
    total++; if (nt !== 16 || hmin !== 4 || hmax !== 4) begin bad++; $display("FAIL m3_sclk: got tog=%0d hp=%0d..%0d exp 16 4..4", nt, hmin, hmax); end
    total++; if (spi_sclk !== 1'b1) begin bad++; $display("FAIL m3_sclk_end: got %b exp 1", spi_sclk); end
    bus_read(SPI_ADDR_DATA, d);
    total++; if (d !== exp_q[0]) begin bad++; $display("FAIL m3_rx: got %h exp %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_collision();
    logic [7:0] d, bits; int cb, tb, scb, nb, nt, hmin, hmax;
    bus_write(SPI_ADDR_CTRL, 8'h02);
    arm(1'b0, 1'b0, 1'b1, 8'h00, cb, tb, scb);
    bus_write(SPI_ADDR_DATA, 8'hA5);
    bus_write(SPI_ADDR_DATA, 8'h55);
    wait_done("col");
    collect(cb, tb, bits, nb, nt, hmin, hmax);
    total++; if (nb !== 8 || bits !== 8'hA5) begin bad++; $display("FAIL col_mosi: got %h/%0d exp a5/8", bits, nb); end
    total++; if (shift_cycles - scb !== 64) begin bad++; $display("FAIL col_len: got %0d exp 64", shift_cycles - scb); end
    bus_read(SPI_ADDR_STATUS, d);
    total++; if (d !== 8'h06) begin bad++; $display("FAIL col_status: got %h exp 06", d); end
    bus_write(SPI_ADDR_STATUS, 8'hFF);
    bus_read(SPI_ADDR_STATUS, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL col_clear: got %h exp 02", d); end
    bus_read(SPI_ADDR_DATA, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL col_rx: got %h exp 00", d); end
  endtask

  task automatic test_irq();
    logic [7:0] d; logic prev, at, seen; int cb, tb, scb;
    bus_write(SPI_ADDR_CTRL, 8'h80);
    arm(1'b0, 1'b0, 1'b1, 8'h5A, cb, tb, scb);
    bus_write(SPI_ADDR_DATA, 8'h3C);
    prev = host_if.irq; at = 1'b0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (dbg_state == ST_DONE) begin seen = 1'b1; at = host_if.irq; end
      else prev = host_if.irq;
    end
    cap_en = 1'b0; s_active = 1'b0;
    total++; if (seen !== 1'b1 || at !== 1'b1 || prev !== 1'b0) begin bad++; $display("FAIL irq_rise: got seen=%b prev=%b at=%b exp 1 0 1", seen, prev, at); end
    repeat (3) @(negedge clock);
    total++; if (host_if.irq !== 1'b1) begin bad++; $display("FAIL irq_hold: got %b exp 1", host_if.irq); end
    bus_read(SPI_ADDR_DATA, d);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL irq_rx: got %h exp 5a", d); end
    total++; if (host_if.irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b exp 0", host_if.irq); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, bits; logic hit; int cb, tb, scb, nb, nt, hmin, hmax;
    bus_write(SPI_ADDR_CTRL, 8'h82);
    bus_write(SPI_ADDR_CS, 8'h03);
    total++; if (spi_cs_n !== 4'b1100) begin bad++; $display("FAIL rm_cs_n: got %b exp 1100", spi_cs_n); end
    arm(1'b0, 1'b0, 1'b0, 8'h00, cb, tb, scb);
    bus_write(SPI_ADDR_DATA, 8'hFF);
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(posedge clock); #1;
      if (tog_q.size() - tb >= 7) hit = 1'b1;
    end
    cap_en = 1'b0;
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL rm_edge7_timeout: got %b exp 1", hit); end
    reset_n = 1'b0;
    #1;
    total++; if (spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin bad++; $display("FAIL rm_pins: got sclk=%b mosi=%b exp 0 0", spi_sclk, spi_mosi); end
    total++; if (spi_cs_n !== 4'hF) begin bad++; $display("FAIL rm_cs_n_rst: got %b exp 1111", spi_cs_n); end
    total++; if (host_if.irq !== 1'b0 || dbg_state !== ST_IDLE) begin bad++; $display("FAIL rm_state: got irq=%b st=%0d exp 0 0", host_if.irq, dbg_state); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    bus_read(SPI_ADDR_STATUS, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rm_status: got %h exp 00", d); end
    bus_write(SPI_ADDR_CS, 8'h01);
    arm(1'b0, 1'b0, 1'b1, 8'h96, cb, tb, scb);
    bus_write(SPI_ADDR_DATA, 8'h69);
    wait_done("rm");
    collect(cb, tb, bits, nb, nt, hmin, hmax);
    total++; if (nb !== 8 || bits !== 8'h69) begin bad++; $display("FAIL rm_mosi: got %h/%0d exp 69/8", bits, nb); end
    bus_read(SPI_ADDR_DATA, d);
    total++; if (d !== 8'h96) begin bad++; $display("FAIL rm_rx: got %h exp 96", d); end
  endtask

  task automatic test_loopback();
    logic [7:0] d, exp_ctrl, exp_rx; int cb, tb, scb;
`ifdef SPI_MASTER_LOOPBACK_EN
    exp_ctrl = 8'h08; exp_rx = 8'hC3;
`else
    exp_ctrl = 8'h00; exp_rx = 8'h00;
`endif
    bus_write(SPI_ADDR_CTRL, 8'h08);
    bus_read(SPI_ADDR_CTRL, d);
    total++; if (d !== exp_ctrl) begin bad++; $display("FAIL lb_ctrl: got %h exp %h", d, exp_ctrl); end
    arm(1'b0, 1'b0, 1'b0, 8'h00, cb, tb, scb);
    bus_write(SPI_ADDR_DATA, 8'hC3);
    wait_done("lb");
    bus_read(SPI_ADDR_DATA, d);
    total++; if (d !== exp_rx) begin bad++; $display("FAIL lb_rx: got %h exp %h", d, exp_rx); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    host_if.chip_enable = 1'b0; host_if.read_write_n = 1'b1;
    host_if.host_address = 2'd0; host_if.host_din = 8'h00;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    test_reset();
    test_mode0();
    test_mode3();
    test_collision();
    test_irq();
    test_reset_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
